// File: rtl/decode_stage_sequencer_pkg.sv
// decode_stage_sequencer_pkg: widths, format codes, hit indices and bundle layout for the decode sequencer
package decode_stage_sequencer_pkg;
  localparam int NUM_FORMATS = 4;
  localparam int PAYLOAD_W = 96;
  localparam int ADDR_W = 64;
  localparam int FIFO_DEPTH = 2;
  localparam int FMT_W = 5;
  localparam int HIT_D = 0;
  localparam int HIT_DQ = 1;
  localparam int HIT_DS = 2;
  localparam int HIT_X = 3;
  localparam int OPCODE_LSB = 90;
  localparam int REG1_LSB = 85;
  localparam int REG2_LSB = 80;
  localparam int REG3_LSB = 75;
  localparam int REG4_LSB = 70;
  localparam int REG2_VAL_OR_ZERO_POS = 66;
  localparam int BIT1_POS = 65;
  localparam int BIT2_POS = 64;
  localparam int IMM_LSB = 0;
  typedef enum logic [FMT_W-1:0] {
    FMT_INVALID = 5'd0,
    FMT_D = 5'd3,
    FMT_DQ = 5'd4,
    FMT_DS = 5'd5,
    FMT_X = 5'd15
  } fmt_e;
  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [ADDR_W-1:0] addr;
    fmt_e fmt;
    logic illegal;
  } entry_t;
  function automatic fmt_e resolve_format(input logic [NUM_FORMATS-1:0] hit);
    return hit == NUM_FORMATS'(1 << HIT_D) ? FMT_D :
           hit == NUM_FORMATS'(1 << HIT_DQ) ? FMT_DQ :
           hit == NUM_FORMATS'(1 << HIT_DS) ? FMT_DS :
           hit == NUM_FORMATS'(1 << HIT_X) ? FMT_X : FMT_INVALID;
  endfunction
endpackage

// File: rtl/decode_stage_sequencer_if.sv
// decode_stage_sequencer_if: fetch, decoder-bank and issue handshakes of the decode sequencer
interface decode_stage_sequencer_if;
  import decode_stage_sequencer_pkg::*;
  logic flush;
  logic fetch_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic fetch_ready;
  logic dec_enable;
  logic [NUM_FORMATS-1:0] fmt_hit;
  logic [PAYLOAD_W-1:0] dec_payload;
  logic issue_valid;
  logic issue_ready;
  logic [PAYLOAD_W-1:0] issue_payload;
  logic [ADDR_W-1:0] issue_addr;
  fmt_e issue_format;
  logic issue_illegal;
  modport master (
    input flush, fetch_valid, fetch_addr, fmt_hit, dec_payload, issue_ready,
    output fetch_ready, dec_enable, issue_valid, issue_payload, issue_addr, issue_format, issue_illegal
  );
  modport slave (
    output flush, fetch_valid, fetch_addr, fmt_hit, dec_payload, issue_ready,
    input fetch_ready, dec_enable, issue_valid, issue_payload, issue_addr, issue_format, issue_illegal
  );
endinterface

// File: rtl/decode_stage_sequencer_fifo.sv
// decode_seq_fifo: power-of-two sync FIFO with flush, occupancy count and async active-low reset
module decode_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= din;
  assign valid = count != '0;
  // empty head reads as zero so issue outputs are clean in and after reset
  assign dout = valid ? mem[rd_ptr] : '0;
endmodule

// File: rtl/decode_stage_sequencer.sv
// decode_stage_sequencer: credit-gated fetch accept, hit-to-format resolve, buffered issue; DECODE_SEQ_PERF_EN adds perf counters
module decode_stage_sequencer
  import decode_stage_sequencer_pkg::*;
(
  input logic clock_i,
  input logic reset_i,
  decode_stage_sequencer_if.master bus
`ifdef DECODE_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] illegal_count
`endif
);
  logic in_flight, pop, push, valid;
  logic [ADDR_W-1:0] addr_q;
  logic [$clog2(FIFO_DEPTH):0] count;
  fmt_e fmt;
  entry_t din, dout;
  assign pop = valid & bus.issue_ready;
  assign push = in_flight & ~bus.flush;
  // the in-flight slot holds a credit so a result always finds FIFO space
  assign bus.fetch_ready = reset_i & ~bus.flush & ((int'(count) + int'(in_flight) - int'(pop)) < FIFO_DEPTH);
  assign bus.dec_enable = bus.fetch_valid & bus.fetch_ready;
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      in_flight <= 1'b0;
      addr_q <= '0;
    end else begin
      in_flight <= bus.dec_enable;
      if (bus.dec_enable) addr_q <= bus.fetch_addr;
    end
  assign fmt = resolve_format(bus.fmt_hit);
  assign din = '{payload: bus.dec_payload, addr: addr_q, fmt: fmt, illegal: fmt == FMT_INVALID};
  decode_seq_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clock_i),
    .rst_n(reset_i),
    .push(push),
    .pop(pop),
    .flush(bus.flush),
    .din(din),
    .dout(dout),
    .valid(valid),
    .count(count)
  );
  assign bus.issue_valid = valid;
  assign bus.issue_payload = dout.payload;
  assign bus.issue_addr = dout.addr;
  assign bus.issue_format = dout.fmt;
  assign bus.issue_illegal = dout.illegal;
`ifdef DECODE_SEQ_PERF_EN
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      stall_cycles <= '0;
      illegal_count <= '0;
    end else begin
      if (bus.fetch_valid && !bus.fetch_ready && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      if (push && din.illegal && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
    end
`endif
endmodule
